// File: rtl/axis_arb_pkg.sv
// Shared types for the packet-locked round-robin stream arbiter, plus a
// behavioural round-robin reference usable by assertions and models.
package axis_arb_pkg;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

  localparam int MAX_PORTS = 16;

  // First asserted request searching upward from last+1, wrapping at n-1 -> 0.
  function automatic logic [3:0] rr_next(input logic [MAX_PORTS-1:0] req,
                                         input logic [3:0]           last,
                                         input int                   n);
    int c;
    rr_next = last;
    for (int k = n; k >= 1; k--) begin
      c = (int'(last) + k) % n;
      if (req[c]) rr_next = 4'(c);
    end
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_rr_priority.sv
// Combinational round-robin pick: rotate the doubled request vector so the
// port after 'last' lands at bit 0, then take the lowest set bit.
module rr_priority #(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_WIDTH-1:0]  last,
  output logic [ID_WIDTH-1:0]  gnt_idx,
  output logic                 gnt_any
);
  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [NUM_PORTS-1:0]   req_rot;
  int                     start;
  int                     pos;

  always_comb begin
    start   = (int'(last) + 1) % NUM_PORTS;
    req_dbl = {req, req};
    req_rot = NUM_PORTS'(req_dbl >> start);
    pos     = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_rot[k]) pos = k;
    end
    gnt_idx = ID_WIDTH'((start + pos) % NUM_PORTS);
    gnt_any = |req;
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter multiplexing NUM_PORTS AXI4-Stream
// requesters onto one sink; the grant is held until tlast or the beat limit.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 0,
  parameter int ID_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  output logic [NUM_PORTS-1:0]            s_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tlast,
  output logic [ID_WIDTH-1:0]             m_tid,
  output logic                            busy
);
  localparam int               CNT_W    = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);

  // Counter never wraps, so a disabled limit cannot alias into a false release.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  arb_state_t            state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_q,  last_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [ID_WIDTH-1:0]   pri_idx;
  logic                  pri_any;
  logic                  locked;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  force_rel;
  logic                  accept;
  logic                  release_now;

  rr_priority #(
    .NUM_PORTS (NUM_PORTS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_pri (
    .req     (s_tvalid),
    .last    (last_q),
    .gnt_idx (pri_idx),
    .gnt_any (pri_any)
  );

  assign locked      = (state_q == LOCKED);
  assign sel_valid   = s_tvalid[grant_q];
  assign sel_last    = s_tlast[grant_q];
  assign sel_data    = s_tdata[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
  assign force_rel   = (MAX_BEATS > 0) && (cnt_q == CNT_LAST);
  assign accept      = locked & sel_valid & m_tready;
  assign release_now = accept & (sel_last | force_rel);
  assign busy        = locked;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_WIDTH'(NUM_PORTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pri_any) begin
          grant_d = pri_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (release_now) begin
          last_d  = grant_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (accept) begin
          cnt_d = sat_inc(cnt_q);
        end
      end
    endcase
  end

  // m_tvalid depends only on registered grant and s_tvalid, never on m_tready.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    m_tid    = '0;
    s_tready = '0;
    if (locked) begin
      m_tvalid          = sel_valid;
      m_tdata           = sel_data;
      m_tlast           = sel_last | force_rel;
      m_tid             = grant_q;
      s_tready[grant_q] = m_tready;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: cycle table for a single requester, then
// scoreboard-checked multi-port scenarios (rotation, backpressure, beat limit, reset).
module tb_axis_rr_arbiter;
  import axis_arb_pkg::*;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     s_tvalid;
  logic [NP-1:0]     s_tready;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP-1:0]     s_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tlast;
  logic [1:0]        m_tid;
  logic              busy;

  always #5 clk = ~clk;

  axis_rr_arbiter #(
    .NUM_PORTS  (NP),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .busy     (busy)
  );

  typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;
  typedef struct packed { logic [1:0] id; logic [DW-1:0] d; logic l; } exp_t;
  typedef struct packed {
    logic [NP-1:0] vld;   logic [NP-1:0] lst;  logic [DW-1:0] dat;  logic rdy;
    logic e_vld;          logic [DW-1:0] e_dat; logic e_lst;        logic [1:0] e_id;
    logic e_busy;         logic [NP-1:0] e_rdy;
  } vec_t;

  beat_t src[NP][$];
  beat_t mq[NP][$];
  int    lens[NP][$];
  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    rdy_mode;
  logic  gap_due;
  vec_t  vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive_src();
    for (int p = 0; p < NP; p++) begin
      if (src[p].size() > 0) begin
        s_tvalid[p]         = 1'b1;
        s_tdata[p*DW +: DW] = src[p][0].d;
        s_tlast[p]          = src[p][0].l;
      end else begin
        s_tvalid[p]         = 1'b0;
        s_tdata[p*DW +: DW] = '0;
        s_tlast[p]          = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int p = 0; p < NP; p++) src[p].delete();
    exp_q.delete();
    gap_due  = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic load(input int p, input int n, input logic [DW-1:0] base, input logic last_end);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = base + DW'(i);
      b.l = last_end && (i == n - 1);
      src[p].push_back(b);
    end
  endtask

  task automatic exp_push(input int id, input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.id = 2'(id);
    e.d  = d;
    e.l  = l;
    exp_q.push_back(e);
  endtask

  // One clock: check at negedge, then update sources and m_tready just after posedge.
  task automatic step();
    logic [NP-1:0] acc;
    logic [NP-1:0] e_rdy;
    exp_t          e;
    @(negedge clk);
    if (gap_due) check("gap_after_release", m_tvalid, 1'b0);
    if (exp_q.size() > 0) begin
      e_rdy = busy ? (4'(m_tready) << exp_q[0].id) : 4'b0;
      check("s_tready", s_tready, e_rdy);
    end
    gap_due = m_tvalid & m_tready & m_tlast;
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_beat: id %0d data %0h arrived with none expected", m_tid, m_tdata);
      end else begin
        e = exp_q.pop_front();
        check("beat", {m_tid, m_tdata, m_tlast}, e);
      end
    end
    acc = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (acc[p] && src[p].size() > 0) src[p].delete(0);
    end
    drive_src();
    case (rdy_mode)
      1:       m_tready = ~m_tready;
      2:       m_tready = ($urandom_range(0, 3) != 0);
      default: m_tready = 1'b1;
    endcase
  endtask

  task automatic run_until_empty(input string name, input int budget);
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      step();
      cyc++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: %0d beats still expected after %0d cycles", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic tail(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Every port gets npk packets of random length; all present continuously, so
  // grant order follows the round-robin reference over ports with packets left.
  task automatic rr_scenario(input int npk, input int maxlen, input int mode);
    int            last;
    int            p;
    int            n;
    logic [15:0]   mask;
    beat_t         b;
    for (int q = 0; q < NP; q++) begin
      lens[q].delete();
      mq[q].delete();
      for (int k = 0; k < npk; k++) begin
        n = int'($urandom_range(1, maxlen));
        lens[q].push_back(n);
        for (int i = 0; i < n; i++) begin
          b.d = 8'($urandom);
          b.l = (i == n - 1);
          src[q].push_back(b);
          mq[q].push_back(b);
        end
      end
    end
    last = NP - 1;
    while (1) begin
      mask = '0;
      for (int q = 0; q < NP; q++) mask[q] = (lens[q].size() > 0);
      if (mask == 16'h0) break;
      p = int'(rr_next(mask, 4'(last), NP));
      n = lens[p].pop_front();
      for (int i = 0; i < n; i++) begin
        b = mq[p].pop_front();
        exp_push(p, b.d, b.l);
      end
      last = p;
    end
    rdy_mode = mode;
    m_tready = 1'b1;
    drive_src();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, %0d compared so far", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [16:0] act;
    logic [16:0] req;

    vecs[0] = '{4'b0100, 4'b0000, 8'hA0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[1] = '{4'b0100, 4'b0000, 8'hA0, 1'b1, 1'b1, 8'hA0, 1'b0, 2'd2, 1'b1, 4'b0100};
    vecs[2] = '{4'b0100, 4'b0000, 8'hA1, 1'b1, 1'b1, 8'hA1, 1'b0, 2'd2, 1'b1, 4'b0100};
    vecs[3] = '{4'b0100, 4'b0100, 8'hA2, 1'b0, 1'b1, 8'hA2, 1'b1, 2'd2, 1'b1, 4'b0000};
    vecs[4] = '{4'b0100, 4'b0100, 8'hA2, 1'b1, 1'b1, 8'hA2, 1'b1, 2'd2, 1'b1, 4'b0100};
    vecs[5] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[6] = '{4'b0100, 4'b0100, 8'hB0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 4'b0000};
    vecs[7] = '{4'b0100, 4'b0100, 8'hB0, 1'b1, 1'b1, 8'hB0, 1'b1, 2'd2, 1'b1, 4'b0100};
    vecs[8] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 4'b0000};

    reset    = 1'b1;
    s_tvalid = '1;
    s_tlast  = '1;
    s_tdata  = 32'hDEADBEEF;
    m_tready = 1'b1;
    rdy_mode = 0;
    gap_due  = 1'b0;
    #2;
    check("reset_outputs", {m_tvalid, s_tready, m_tlast, m_tdata, m_tid, busy}, '0);

    // Single requester, cycle by cycle.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      s_tvalid = vecs[i].vld;
      s_tlast  = vecs[i].lst;
      s_tdata  = {8'h00, vecs[i].dat, 16'h0000};
      m_tready = vecs[i].rdy;
      @(negedge clk);
      act = {m_tvalid, busy, s_tready, (m_tvalid ? {m_tdata, m_tlast, m_tid} : 11'h0)};
      req = {vecs[i].e_vld, vecs[i].e_busy, vecs[i].e_rdy,
             (vecs[i].e_vld ? {vecs[i].e_dat, vecs[i].e_lst, vecs[i].e_id} : 11'h0)};
      check($sformatf("vec%0d", i), act, req);
      @(posedge clk);
      #1;
    end

    // All ports, single-beat packets: rotation 0,1,2,3,0,1,2,3.
    do_reset();
    rr_scenario(2, 1, 0);
    run_until_empty("rotation", 200);
    tail(3);

    // Port 1 packet under toggling ready while port 3 waits.
    do_reset();
    load(1, 4, 8'h30, 1'b1);
    load(3, 2, 8'h40, 1'b1);
    for (int i = 0; i < 4; i++) exp_push(1, 8'h30 + 8'(i), i == 3);
    exp_push(3, 8'h40, 1'b0);
    exp_push(3, 8'h41, 1'b1);
    rdy_mode = 1;
    drive_src();
    run_until_empty("toggle_ready", 200);
    tail(3);

    // Beat limit: port 0 streams 10 beats without tlast, port 1 waiting.
    do_reset();
    load(0, 10, 8'h00, 1'b0);
    load(1, 2, 8'h90, 1'b1);
    for (int i = 0; i < 4; i++) exp_push(0, 8'(i), i == 3);
    exp_push(1, 8'h90, 1'b0);
    exp_push(1, 8'h91, 1'b1);
    for (int i = 4; i < 8; i++) exp_push(0, 8'(i), i == 7);
    exp_push(0, 8'h08, 1'b0);
    exp_push(0, 8'h09, 1'b0);
    rdy_mode = 2;
    drive_src();
    run_until_empty("beat_limit", 400);
    tail(3);
    @(negedge clk);
    check("grant_held_without_valid", {busy, m_tvalid}, 2'b10);
    @(posedge clk);
    #1;

    // Reset in the middle of a port 2 packet, after port 0 was last served.
    do_reset();
    load(0, 1, 8'h50, 1'b1);
    exp_push(0, 8'h50, 1'b1);
    drive_src();
    run_until_empty("pre_reset", 50);
    load(2, 5, 8'h60, 1'b1);
    exp_push(2, 8'h60, 1'b0);
    exp_push(2, 8'h61, 1'b0);
    drive_src();
    run_until_empty("mid_packet", 50);
    reset = 1'b1;
    #1;
    check("reset_mid_packet", {m_tvalid, s_tready, busy}, '0);
    for (int p = 0; p < NP; p++) src[p].delete();
    exp_q.delete();
    gap_due = 1'b0;
    drive_src();
    @(posedge clk);
    #1 reset = 1'b0;
    load(0, 1, 8'h70, 1'b1);
    load(2, 1, 8'h80, 1'b1);
    exp_push(0, 8'h70, 1'b1);
    exp_push(2, 8'h80, 1'b1);
    drive_src();
    run_until_empty("post_reset_priority", 50);
    tail(3);

    // Random packets on all ports with random backpressure.
    do_reset();
    rr_scenario(3, MB, 2);
    run_until_empty("random_traffic", 2000);
    tail(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Round-robin arbiter that shares one AXI4-Stream sink (the write side of a fifo instance) between NUM_PORTS stream requesters.
- Grants are packet-locked: a grant is held until the beat carrying tlast is accepted, or until an optional beat limit forces release.
- Sits in front of the fifo write interface. Output is a single stream plus the granted port index, so the downstream side can tag or route data.

Parameters:
NUM_PORTS, 4, number of requesting slave streams (2..16)
DATA_WIDTH, 8, tdata width per stream
MAX_BEATS, 0, forced release after this many beats without tlast; 0 disables the limit
ID_WIDTH, $clog2(NUM_PORTS), width of grant index (derived, do not override)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
s_tvalid  input  NUM_PORTS  per-requester valid
s_tready  output  NUM_PORTS  per-requester ready
s_tdata  input  NUM_PORTS*DATA_WIDTH  packed requester data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
s_tlast  input  NUM_PORTS  per-requester end-of-packet
m_tvalid  output  1  output valid
m_tready  input  1  output ready (fifo write tready)
m_tdata  output  DATA_WIDTH  output data
m_tlast  output  1  output end-of-packet (also high on forced release beat)
m_tid  output  ID_WIDTH  index of currently granted port
busy  output  1  high while a grant is held

Behaviour:
- State machine, two states:
  - IDLE: no grant.
  - LOCKED: grant held on register grant_q.
- Reset (async, immediate):
  - state=IDLE, grant_q=0, last_q=NUM_PORTS-1 (port 0 has first priority), beat_cnt=0.
  - Outputs: m_tvalid=0, s_tready=0, m_tlast=0, m_tdata=0, m_tid=0, busy=0.
- IDLE:
  - All s_tready=0, m_tvalid=0.
  - If any s_tvalid is high, select the first asserted port searching from last_q+1 upward with wrap-around at NUM_PORTS-1 -> 0.
  - Register it into grant_q and go to LOCKED.
  - Arbitration latency is exactly 1 cycle from s_tvalid to the first possible m_tvalid.
- LOCKED, combinational pass-through of the granted port:
  - m_tvalid=s_tvalid[grant_q], m_tdata=s_tdata[grant_q], m_tid=grant_q.
  - s_tready[grant_q]=m_tready; all other s_tready=0.
  - m_tlast = s_tlast[grant_q] OR forced-release condition.
- Beat accepted when m_tvalid & m_tready:
  - beat_cnt increments on every accepted beat.
  - Release when the accepted beat has s_tlast[grant_q]=1, or when MAX_BEATS!=0 and beat_cnt==MAX_BEATS-1.
  - On release: last_q<=grant_q, beat_cnt<=0, state<=IDLE.
- Release costs one idle cycle. Back-to-back packets from different ports are separated by exactly one cycle with m_tvalid=0.
- Granted port dropping tvalid mid-packet does not release the grant. The arbiter waits indefinitely unless the MAX_BEATS limit is reached.
- Non-granted requesters see s_tready=0 and must hold their data (AXI rule). No data is ever dropped or duplicated.
- A single requester repeatedly requesting is re-granted each time, after one idle cycle.
- Fairness: with all ports continuously requesting, grants rotate 0,1,2,...,NUM_PORTS-1,0.
- Reset asserted mid-packet aborts the grant immediately. The partial packet is not completed. After reset, port 0 has priority again.
- beat_cnt width is $clog2(MAX_BEATS+1) (min 1). It saturates safely if MAX_BEATS=0.
- No combinational path from m_tready to m_tvalid.

Decomposition:
- Package axis_arb_pkg:
  - typedef enum logic {IDLE, LOCKED} arb_state_t.
  - Function rr_next(req, last) for use in assertions and the bench model.
- One sub-module rr_priority, purely combinational:
  - Inputs: req[NUM_PORTS], last[ID_WIDTH].
  - Outputs: gnt_idx[ID_WIDTH], gnt_any.
  - Implemented as a double-width rotate-and-find-first.
- Top holds the FSM, counters and the data mux.

Test Plan:
- Reset then port 2 only sends 3-beat packet A0,A1,A2 (tlast on A2) with m_tready=1 -> m_tvalid first high 1 cycle after s_tvalid[2]; m_tid=2; m_tdata=A0,A1,A2; m_tlast on A2; busy low the cycle after.
- All 4 ports continuously send 1-beat packets -> grant order 0,1,2,3,0,1; one m_tvalid=0 cycle between each; m_tid matches.
- Port 1 grant, 4-beat packet, m_tready toggles 1,0,1,0,...; port 3 requesting throughout -> port 1 data uninterrupted and in order; s_tready[3]=0 until port 1 tlast accepted; then m_tid=3.
- MAX_BEATS=4, port 0 streams 10 beats with no tlast, port 1 requesting -> m_tlast forced on beat 4; next grant port 1; port 0 resumes later with beat 5.
- Assert reset while port 2 is mid-packet (beat 2 of 5) -> immediately m_tvalid=0, s_tready=0, busy=0; after release, ports 0 and 2 both request -> port 0 granted first.
- End-to-end with fifo (ADDR_WIDTH=5) downstream: 4 ports x 8 random bytes -> fifo read stream equals the per-packet concatenation in grant order; no loss; fifo full backpressure stalls the arbiter without corruption.
